// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Purpose  : Synchronise, debounce and edge-detect pushbuttons; capture digit
//            switches alongside the channel-0 press strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int CNT_W           = 16
) (
  input  logic             i_clk,
  input  logic             i_hard_reset_n,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [3:0]       i_digit,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_pulse,
  output logic [3:0]       o_digit,
  output logic             o_digit_valid
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_pulse;
  logic [N_BTN-1:0] w_press_now;

  generate
    for (genvar k = 0; k < N_BTN; k++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_pulse;
      logic             w_differs;
      logic             w_expire;

      assign w_differs = (r_s2 != r_level);
      assign w_expire  = w_differs && (r_cnt == C_CNT_MAX);

      always_ff @(posedge i_clk or negedge i_hard_reset_n) begin
        if (!i_hard_reset_n) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_s1 <= i_btn[k];
          r_s2 <= r_s1;
          // Any cycle agreeing with the current level restarts the count.
          if (!w_differs) begin
            r_cnt <= '0;
          end else if (w_expire) begin
            r_level <= r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          r_pulse <= w_expire && r_s2;
        end
      end

      assign w_level[k]     = r_level;
      assign w_pulse[k]     = r_pulse;
      assign w_press_now[k] = w_expire && r_s2;
    end
  endgenerate

  logic [3:0] r_dig_s1;
  logic [3:0] r_dig_s2;
  logic [3:0] r_digit;

  // The digit is sampled on the same edge that raises the channel-0 pulse.
  always_ff @(posedge i_clk or negedge i_hard_reset_n) begin
    if (!i_hard_reset_n) begin
      r_dig_s1 <= 4'h0;
      r_dig_s2 <= 4'h0;
      r_digit  <= 4'h0;
    end else begin
      r_dig_s1 <= i_digit;
      r_dig_s2 <= r_dig_s1;
      if (w_press_now[0]) begin
        r_digit <= r_dig_s2;
      end
    end
  end

  assign o_btn_level   = w_level;
  assign o_btn_pulse   = w_pulse;
  assign o_digit       = r_digit;
  assign o_digit_valid = w_pulse[0];

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module   : tb_button_debouncer
// Purpose  : Directed vector bench for button_debouncer with DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn;
  logic [3:0] digit;
  logic [2:0] level;
  logic [2:0] pulse;
  logic [3:0] odig;
  logic       valid;

  int checks;
  int errors;

  button_debouncer #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .i_clk         (clk),
    .i_hard_reset_n(rst_n),
    .i_btn         (btn),
    .i_digit       (digit),
    .o_btn_level   (level),
    .o_btn_pulse   (pulse),
    .o_digit       (odig),
    .o_digit_valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [3:0] digit;
    logic [2:0] exp_level;
    logic [2:0] exp_pulse;
    logic [3:0] exp_digit;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] l, input logic [2:0] p,
                           input logic [3:0] d, input logic v);
    check({tag, ".level"}, 32'(level), 32'(l));
    check({tag, ".pulse"}, 32'(pulse), 32'(p));
    check({tag, ".digit"}, 32'(odig),  32'(d));
    check({tag, ".valid"}, 32'(valid), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn    = 3'b000;
    digit  = 4'h0;

    // Press ch0 with digit B: edges 1..5 quiet, pulse on edge 6 (E0+5).
    for (int i = 0; i < 5; i++) vecs[i] = '{3'b001, 4'hB, 3'b000, 3'b000, 4'h0, 1'b0};
    vecs[5] = '{3'b001, 4'hB, 3'b001, 3'b001, 4'hB, 1'b1};
    vecs[6] = '{3'b001, 4'hB, 3'b001, 3'b000, 4'hB, 1'b0};
    vecs[7] = '{3'b001, 4'hB, 3'b001, 3'b000, 4'hB, 1'b0};
    // Digit changes while held: captured value must not follow.
    for (int i = 8; i < 12; i++) vecs[i] = '{3'b001, 4'hD, 3'b001, 3'b000, 4'hB, 1'b0};

    repeat (3) tick();
    check_all("reset", 3'b000, 3'b000, 4'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      btn   = vecs[i].btn;
      digit = vecs[i].digit;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_level, vecs[i].exp_pulse,
                vecs[i].exp_digit, vecs[i].exp_valid);
    end

    // Ch1 toggling every 2 clocks never reaches the debounce count.
    for (int i = 0; i < 16; i++) begin
      btn = {1'b0, (i < 8) ? ((i % 4) < 2) : 1'b0, 1'b1};
      tick();
      check($sformatf("toggle%0d.level", i), 32'(level), 32'(3'b001));
      check($sformatf("toggle%0d.pulse", i), 32'(pulse), 32'(3'b000));
    end

    // Ch1 bounces then settles: one pulse 5 edges after the final edge.
    btn = 3'b011; tick();
    btn = 3'b001; tick();
    btn = 3'b011;
    for (int k = 0; k <= 10; k++) begin
      tick();
      check($sformatf("bounce%0d.pulse", k), 32'(pulse), 32'((k == 5) ? 3'b010 : 3'b000));
      check($sformatf("bounce%0d.level", k), 32'(level), 32'((k >= 5) ? 3'b011 : 3'b001));
    end
    btn = 3'b001;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check($sformatf("release%0d.level", k), 32'(level), 32'((k < 5) ? 3'b011 : 3'b001));
      check($sformatf("release%0d.pulse", k), 32'(pulse), 32'(3'b000));
    end

    // All released, then simultaneous press of every channel.
    btn = 3'b000;
    repeat (10) tick();
    check("idle.level", 32'(level), 32'(3'b000));
    digit = 4'h5;
    btn   = 3'b111;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check_all($sformatf("simul%0d", k), (k >= 5) ? 3'b111 : 3'b000,
                (k == 5) ? 3'b111 : 3'b000, (k >= 5) ? 4'h5 : 4'hB, k == 5);
    end

    // Reset mid-count with ch0 held through release.
    btn = 3'b000;
    repeat (10) tick();
    digit = 4'h9;
    btn   = 3'b001;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all("inrst", 3'b000, 3'b000, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("inrst%0d", k), 3'b000, 3'b000, 4'h0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check_all($sformatf("postrst%0d", k), (k >= 5) ? 3'b001 : 3'b000,
                (k == 5) ? 3'b001 : 3'b000, (k >= 5) ? 4'h9 : 4'h0, k == 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
